fmac_pktctrl_wr_arb: RTL and testbench
======================================

// Module: fmac_pktctrl_wr_arb
// PURPOSE
//  Round-robin write arbiter sharing one 4Kx32 packet-control FIFO between NREQ requesters.
//  A requester asks for a burst of 1..MAXBURST words. The arbiter grants only if the FIFO
//  has room for the whole burst. It then forwards that requester's words, registered, to
//  the FIFO write port. Bursts are atomic: words from different requesters never interleave.
// PARAMETERS
//  NREQ     4     number of requesters (2..8)
//  WIDTH    32    FIFO word width
//  PTR      12    FIFO address width; DEPTH = 2**PTR = 4096
//  MAXBURST 16    max words per burst; LENW = clog2(MAXBURST+1) = 5
// PORTS
//  clk        in   1           single clock, shared with FIFO
//  srst       in   1           synchronous active-high reset, shared with FIFO
//  req        in   NREQ        req[i]=1: requester i wants a burst; held until gnt[i]
//  req_len    in   NREQ*LENW   burst length of req i in words, slice i; stable while req[i]
//  wr_valid   in   NREQ        word valid from requester i
//  wr_data    in   NREQ*WIDTH  word from requester i, slice i
//  gnt        out  NREQ        one-hot grant, registered
//  fifo_wrreq out  1           to FIFO wrreq, registered
//  fifo_data  out  WIDTH       to FIFO data, registered
//  fifo_full  in   1           FIFO wrfull
//  fifo_usedw in   PTR+1       FIFO wrusedw; only bits [PTR-1:0] are meaningful
//  busy       out  1           state != IDLE
// BEHAVIOUR
//  Reset values:
//   - outputs: gnt=0, fifo_wrreq=0, fifo_data=0, busy=0.
//   - internal: state=IDLE, rr_ptr=0, word count=0.
//  Space check:
//   - used = fifo_full ? DEPTH : fifo_usedw[PTR-1:0]. This covers data_count wrapping to 0 when full.
//   - free = DEPTH - used, computed at PTR+1 bits.
//   - requester i is eligible iff req[i] && len_i != 0 && len_i <= MAXBURST && len_i <= free.
//   - len 0 or len > MAXBURST: never granted.
//  States:
//   - IDLE: search eligible requesters from rr_ptr upward, wrapping mod NREQ; first hit wins.
//     On a hit: latch idx and len, cnt=0, gnt<=onehot(idx), rr_ptr<=(idx+1)%NREQ, go BURST.
//     With no hit, stay in IDLE.
//   - BURST: each cycle wr_valid[idx] is sampled while gnt[idx]=1.
//     For each sampled word: fifo_wrreq<=1, fifo_data<=wr_data[idx], cnt++.
//     Otherwise fifo_wrreq<=0.
//     When the len-th word is sampled: gnt<=0 next cycle, go SETTLE0.
//     No timeout; the grant is held until len words have arrived.
//   - SETTLE0 -> SETTLE1 -> IDLE: 2 cycles covering the registered write and the FIFO
//     usedw update, so the next space check sees the true count.
//  Latency:
//   - req sampled in IDLE at cycle N -> gnt high at N+1.
//   - wr_valid at cycle M -> fifo_wrreq at M+1.
//   - Minimum grant-to-grant gap = len+3 cycles.
//  Ignored inputs:
//   - wr_valid of non-granted requesters is ignored.
//   - wr_valid after the len-th word is ignored.
//   - The FIFO is never overfilled: admission guarantees room, and reads only add space.
//  Simultaneous requests: resolved by rr_ptr only.
//  A requester that is not eligible for lack of space does not block others that fit.
//  Reset mid-burst: all state returns to reset values immediately.
//   The partial burst is discarded by the FIFO's own srst.
//  Arithmetic: cnt and len are LENW bits; free is PTR+1 bits, so there is no overflow at DEPTH.
// TESTING
//  1 Reset, req[0]=1, len=4, usedw=0: gnt=0001 at +1; 4 valid words give 4 fifo_wrreq with
//    matching data; gnt=0 after word 4; busy low 3 cycles after the last word.
//  2 req=1111, all len=2, FIFO empty: grants in order 0,1,2,3,0; no data interleaving.
//  3 usedw=4090, req[1] len=8, req[2] len=6: only req 2 granted. Once FIFO reads lower
//    usedw to 4088, req 1 is granted.
//  4 fifo_full=1, usedw=0 (wrap case), req[0] len=1: no grant.
//    Release full with usedw=4095: grant.
//  5 len=0 on req 3 with req 2 len=3: req 3 never granted; req 2 served normally.
//  6 srst pulsed during BURST after word 2 of 5: next cycle gnt=0, fifo_wrreq=0, busy=0, rr_ptr=0.

Source files
------------

// File: rtl/fmac_pktctrl_wr_arb.sv
// Round-robin write arbiter sharing one packet-control FIFO between NREQ requesters.
// A burst is granted only when the FIFO has room for all of it, and bursts never interleave.
module fmac_pktctrl_wr_arb #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int PTR      = 12,
    parameter int MAXBURST = 16,
    localparam int LENW    = $clog2(MAXBURST + 1),
    localparam int IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*LENW-1:0]   req_len,
    input  logic [NREQ-1:0]        wr_valid,
    input  logic [NREQ*WIDTH-1:0]  wr_data,
    output logic [NREQ-1:0]        gnt,
    output logic                   fifo_wrreq,
    output logic [WIDTH-1:0]       fifo_data,
    input  logic                   fifo_full,
    input  logic [PTR:0]           fifo_usedw,
    output logic                   busy
);

    localparam logic [PTR:0] DEPTH = (PTR + 1)'(1) << PTR;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        SETTLE0 = 2'd2,
        SETTLE1 = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              wrreq_q, wrreq_d;
    logic [WIDTH-1:0]  data_q, data_d;

    logic [PTR:0]      used;
    logic [PTR:0]      free;
    logic [NREQ-1:0]   elig;
    logic              hit;
    logic [IDXW-1:0]   hit_idx;
    logic              unused_usedw_msb;

    // The usedw MSB is not meaningful; fullness is taken from fifo_full instead.
    assign unused_usedw_msb = fifo_usedw[PTR];

    function automatic logic [LENW-1:0] len_of(input int i);
        return req_len[i*LENW +: LENW];
    endfunction

    always_comb begin
        used = fifo_full ? DEPTH : {1'b0, fifo_usedw[PTR-1:0]};
        free = DEPTH - used;
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req[i]
                   && (len_of(i) != '0)
                   && (len_of(i) <= LENW'(MAXBURST))
                   && ((PTR + 1)'(len_of(i)) <= free);
        end
    end

    // First eligible requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin : search
        int cand;
        cand    = 0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!hit && elig[cand]) begin
                hit     = 1'b1;
                hit_idx = IDXW'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        wrreq_d  = 1'b0;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    idx_d    = hit_idx;
                    len_d    = len_of(int'(hit_idx));
                    cnt_d    = '0;
                    gnt_d    = NREQ'(1) << hit_idx;
                    rr_ptr_d = (hit_idx == IDXW'(NREQ - 1)) ? '0 : hit_idx + 1'b1;
                    state_d  = BURST;
                end
            end
            BURST: begin
                if (wr_valid[idx_q] && gnt_q[idx_q]) begin
                    wrreq_d = 1'b1;
                    data_d  = wr_data[idx_q*WIDTH +: WIDTH];
                    cnt_d   = cnt_q + 1'b1;
                    if ((cnt_q + 1'b1) == len_q) begin
                        gnt_d   = '0;
                        state_d = SETTLE0;
                    end
                end
            end
            // Two quiet cycles let the last write land and usedw catch up.
            SETTLE0: state_d = SETTLE1;
            SETTLE1: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            wrreq_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            wrreq_q  <= wrreq_d;
            data_q   <= data_d;
        end
    end

    assign gnt        = gnt_q;
    assign fifo_wrreq = wrreq_q;
    assign fifo_data  = data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fmac_pktctrl_wr_arb.sv
// Self-checking bench for fmac_pktctrl_wr_arb: requester agent plus in-order write scoreboard.
module tb_fmac_pktctrl_wr_arb;
    localparam int NREQ     = 4;
    localparam int WIDTH    = 32;
    localparam int PTR      = 12;
    localparam int MAXBURST = 16;
    localparam int LENW     = 5;

    logic                  clk = 1'b0;
    logic                  srst;
    logic [NREQ-1:0]       req;
    logic [NREQ*LENW-1:0]  req_len;
    logic [NREQ-1:0]       wr_valid;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_wrreq;
    logic [WIDTH-1:0]      fifo_data;
    logic                  fifo_full;
    logic [PTR:0]          fifo_usedw;
    logic                  busy;

    always #5 clk = ~clk;

    fmac_pktctrl_wr_arb #(
        .NREQ(NREQ), .WIDTH(WIDTH), .PTR(PTR), .MAXBURST(MAXBURST)
    ) dut (
        .clk(clk), .srst(srst), .req(req), .req_len(req_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .gnt(gnt),
        .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
        .fifo_full(fifo_full), .fifo_usedw(fifo_usedw), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int writes_seen = 0;
    int seq = 0;
    int want[NREQ];
    int len_cfg[NREQ];
    int rem[NREQ];
    bit stall_en;
    logic [NREQ-1:0] gnt_prev;
    logic [WIDTH-1:0] exp_q[$];
    int grant_log[$];
    int grant_cyc[$];

    // One clock: check any write against the scoreboard, track grants, drive the next cycle.
    task automatic step();
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] d;
        @(posedge clk);
        #1;
        cyc++;
        if (fifo_wrreq) begin
            writes_seen++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_write: got data %h, required no write", fifo_data);
            end else begin
                e = exp_q.pop_front();
                if (fifo_data !== e) begin
                    miscompares++;
                    $display("FAIL sb_data: got %h, required %h", fifo_data, e);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && !gnt_prev[i]) begin
                grant_log.push_back(i);
                grant_cyc.push_back(cyc);
                rem[i] = len_cfg[i];
                if (want[i] > 0) want[i]--;
            end
        end
        gnt_prev = gnt;
        for (int i = 0; i < NREQ; i++) begin
            req_len[i*LENW +: LENW] = LENW'(len_cfg[i]);
            req[i] = (want[i] > 0) && !gnt[i] && (rem[i] == 0);
            if (gnt[i] && rem[i] > 0 && !(stall_en && $urandom_range(0, 2) == 0)) begin
                seq++;
                d = {4'(i), 12'(seq), 16'($urandom)};
                wr_valid[i] = 1'b1;
                wr_data[i*WIDTH +: WIDTH] = d;
                exp_q.push_back(d);
                rem[i]--;
            end else if (gnt[i] && rem[i] > 0) begin
                wr_valid[i] = 1'b0;
                wr_data[i*WIDTH +: WIDTH] = $urandom;
            end else begin
                wr_valid[i] = 1'($urandom);
                wr_data[i*WIDTH +: WIDTH] = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        srst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            want[i] = 0;
            rem[i] = 0;
            len_cfg[i] = 1;
        end
        req = '0;
        wr_valid = '0;
        fifo_full = 1'b0;
        fifo_usedw = '0;
        stall_en = 1'b0;
        exp_q.delete();
        grant_log.delete();
        grant_cyc.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        gnt_prev = '0;
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int k = 0;
        while (grant_log.size() < n && k < budget) begin
            step();
            k++;
        end
        vectors++;
        if (grant_log.size() < n) begin
            miscompares++;
            $display("FAIL %s_grant_timeout: got %0d grants, required %0d", name, grant_log.size(), n);
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        bit pending = 1'b1;
        while (pending && k < 300) begin
            step();
            k++;
            pending = (exp_q.size() != 0) || busy;
            for (int i = 0; i < NREQ; i++) if (rem[i] != 0) pending = 1'b1;
        end
        vectors++;
        if (pending) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d words outstanding busy=%0b, required 0 and idle",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({gnt, fifo_wrreq, fifo_data, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt=%b wrreq=%b data=%h busy=%b, required all zero",
                     gnt, fifo_wrreq, fifo_data, busy);
        end
        for (int k = 0; k < 3; k++) step();
        vectors++;
        if (gnt !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got gnt=%b busy=%b, required 0000 and 0", gnt, busy);
        end
    endtask

    task automatic test_single_burst();
        int ws;
        do_reset();
        len_cfg[0] = 4;
        want[0] = 1;
        step();
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_gnt_early: got %b, required 0000", gnt);
        end
        step();
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_gnt_plus1: got %b, required 0001", gnt);
        end
        ws = writes_seen;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k < 4) begin
                vectors++;
                if (gnt !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL single_gnt_hold: got %b, required 0001 at word %0d", gnt, k);
                end
            end
            if (k == 4) begin
                vectors++;
                if (gnt !== 4'b0000 || (writes_seen - ws) != 4 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_end: got gnt=%b writes=%0d busy=%b, required 0000 4 1",
                             gnt, writes_seen - ws, busy);
                end
            end
            if (k == 5) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_settle: got busy=%b, required 1", busy);
                end
            end
            if (k == 6) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_idle: got busy=%b, required 0", busy);
                end
            end
        end
        drain("single");
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            len_cfg[i] = 2;
            want[i] = 1;
        end
        want[0] = 2;
        wait_grants(5, 100, "rr");
        drain("rr");
        vectors++;
        if (grant_log.size() != 5) begin
            miscompares++;
            $display("FAIL rr_count: got %0d grants, required 5", grant_log.size());
        end
        for (int g = 0; g < 5 && g < grant_log.size(); g++) begin
            vectors++;
            if (grant_log[g] != exp_order[g]) begin
                miscompares++;
                $display("FAIL rr_order: got req %0d at grant %0d, required %0d", grant_log[g], g, exp_order[g]);
            end
        end
        for (int g = 1; g < 5 && g < grant_cyc.size(); g++) begin
            vectors++;
            if (grant_cyc[g] - grant_cyc[g-1] != 5) begin
                miscompares++;
                $display("FAIL rr_gap: got %0d cycles, required 5", grant_cyc[g] - grant_cyc[g-1]);
            end
        end
    endtask

    task automatic test_space_check();
        do_reset();
        stall_en = 1'b1;
        fifo_usedw = 13'd4090;
        len_cfg[1] = 8;
        len_cfg[2] = 6;
        want[1] = 1;
        want[2] = 1;
        wait_grants(1, 40, "space");
        drain("space_first");
        for (int k = 0; k < 10; k++) step();
        vectors++;
        if (grant_log.size() != 1 || grant_log[0] != 2) begin
            miscompares++;
            $display("FAIL space_only_fit: got %0d grants first=%0d, required 1 grant to req 2",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        end
        fifo_usedw = 13'd4088;
        wait_grants(2, 20, "space_after_read");
        drain("space_second");
        vectors++;
        if (grant_log.size() != 2 || grant_log[grant_log.size()-1] != 1) begin
            miscompares++;
            $display("FAIL space_after_read: got %0d grants last=%0d, required 2 grants last req 1",
                     grant_log.size(), grant_log[grant_log.size()-1]);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        fifo_full = 1'b1;
        fifo_usedw = 13'd0;
        len_cfg[0] = 1;
        want[0] = 1;
        for (int k = 0; k < 20; k++) step();
        vectors++;
        if (grant_log.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_wrap_nogrant: got %0d grants busy=%b, required 0 and 0", grant_log.size(), busy);
        end
        fifo_full = 1'b0;
        fifo_usedw = 13'd4095;
        wait_grants(1, 10, "full_release");
        drain("full_release");
        vectors++;
        if (grant_log.size() != 1 || grant_log[0] != 0) begin
            miscompares++;
            $display("FAIL full_release_grant: got %0d grants, required 1 grant to req 0", grant_log.size());
        end
    endtask

    task automatic test_len_limits();
        do_reset();
        stall_en = 1'b1;
        len_cfg[3] = 0;
        len_cfg[2] = 3;
        want[3] = 1;
        want[2] = 1;
        wait_grants(1, 20, "len0");
        drain("len0");
        for (int k = 0; k < 15; k++) step();
        vectors++;
        if (grant_log.size() != 1 || grant_log[0] != 2) begin
            miscompares++;
            $display("FAIL len0_never: got %0d grants first=%0d, required 1 grant to req 2",
                     grant_log.size(), grant_log[0]);
        end
        want[3] = 0;
        step();
        step();
        len_cfg[3] = MAXBURST + 1;
        want[3] = 1;
        for (int k = 0; k < 15; k++) step();
        vectors++;
        if (grant_log.size() != 1) begin
            miscompares++;
            $display("FAIL len_over_max: got %0d grants, required 1", grant_log.size());
        end
        want[3] = 0;
        step();
        step();
        len_cfg[3] = MAXBURST;
        want[3] = 1;
        wait_grants(2, 20, "len_max");
        drain("len_max");
        vectors++;
        if (grant_log.size() != 2 || grant_log[grant_log.size()-1] != 3) begin
            miscompares++;
            $display("FAIL len_max_grant: got %0d grants, required 2 with last req 3", grant_log.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int ws;
        int k = 0;
        do_reset();
        len_cfg[1] = 5;
        want[1] = 1;
        wait_grants(1, 10, "midrst");
        ws = writes_seen;
        while ((writes_seen - ws) < 2 && k < 20) begin
            step();
            k++;
        end
        srst = 1'b1;
        step();
        vectors++;
        if (gnt !== 4'b0000 || fifo_wrreq !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got gnt=%b wrreq=%b busy=%b, required 0000 0 0",
                     gnt, fifo_wrreq, busy);
        end
        srst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            want[i] = 0;
        end
        exp_q.delete();
        grant_log.delete();
        len_cfg[0] = 1;
        len_cfg[3] = 1;
        want[0] = 1;
        want[3] = 1;
        wait_grants(2, 30, "midrst_rr");
        drain("midrst");
        vectors++;
        if (grant_log.size() < 2 || grant_log[0] != 0 || grant_log[1] != 3) begin
            miscompares++;
            $display("FAIL midrst_rr_ptr: got first grant %0d, required order 0 then 3",
                     (grant_log.size() > 0) ? grant_log[0] : -1);
        end
    endtask

    initial begin
        srst = 1'b1;
        req = '0;
        req_len = '0;
        wr_valid = '0;
        wr_data = '0;
        fifo_full = 1'b0;
        fifo_usedw = '0;
        gnt_prev = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_space_check();
        test_full_wrap();
        test_len_limits();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
